// File: rtl/food_generator.sv
// Food coordinate supplier: draws LFSR candidates, scans them serially against both snakes
// and the other food slot, and hands a clean position to the requesting slot with a 1-cycle pulse.
module food_generator #(
  parameter int          X_MAX     = 160,
  parameter int          Y_MAX     = 120,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_RETRY = 8,
  parameter int          FOOD1_X0  = 40,
  parameter int          FOOD1_Y0  = 60,
  parameter int          FOOD2_X0  = 120,
  parameter int          FOOD2_Y0  = 60
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go_signal,
  input  logic       food_valid_1,
  input  logic       food_valid_2,
  input  logic [7:0] snake_1_x [64],
  input  logic [6:0] snake_1_y [64],
  input  logic [7:0] snake_2_x [64],
  input  logic [6:0] snake_2_y [64],
  input  logic [5:0] snake_1_size,
  input  logic [5:0] snake_2_size,
  output logic [7:0] new_food_x1,
  output logic [6:0] new_food_y1,
  output logic [7:0] new_food_x2,
  output logic [6:0] new_food_y2,
  output logic       food_received_1,
  output logic       food_received_2
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, GEN, CHECK, DONE, HOLD} state_t;

  // Single conditional subtract folds the raw LFSR field onto the playfield.
  function automatic logic [7:0] wrap_x(input logic [7:0] v);
    return (v >= 8'(X_MAX)) ? v - 8'(X_MAX) : v;
  endfunction

  function automatic logic [6:0] wrap_y(input logic [6:0] v);
    return (v >= 7'(Y_MAX)) ? v - 7'(Y_MAX) : v;
  endfunction

  state_t          state;
  logic [15:0]     lfsr;
  logic [15:0]     lfsr_next;
  logic [7:0]      cand_x;
  logic [6:0]      cand_y;
  logic [5:0]      idx;
  logic            hit;
  logic            scan_hit;
  logic            slot2;
  logic [RW-1:0]   retries;
  logic [7:0]      other_x;
  logic [6:0]      other_y;

  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    other_x   = slot2 ? new_food_x1 : new_food_x2;
    other_y   = slot2 ? new_food_y1 : new_food_y2;
    scan_hit  = ((idx < snake_1_size) && (cand_x == snake_1_x[idx]) && (cand_y == snake_1_y[idx]))
             || ((idx < snake_2_size) && (cand_x == snake_2_x[idx]) && (cand_y == snake_2_y[idx]))
             || ((cand_x == other_x) && (cand_y == other_y));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= LFSR_SEED;
    else         lfsr <= lfsr_next;
  end

  always_ff @(posedge clk) begin
    if (state == GEN) begin
      cand_x <= wrap_x(lfsr[7:0]);
      cand_y <= wrap_y(lfsr[14:8]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      slot2           <= 1'b0;
      idx             <= 6'd0;
      hit             <= 1'b0;
      retries         <= '0;
      new_food_x1     <= 8'(FOOD1_X0);
      new_food_y1     <= 7'(FOOD1_Y0);
      new_food_x2     <= 8'(FOOD2_X0);
      new_food_y2     <= 7'(FOOD2_Y0);
      food_received_1 <= 1'b0;
      food_received_2 <= 1'b0;
    end else if (!go_signal && state != IDLE) begin
      state           <= IDLE;
      retries         <= '0;
      food_received_1 <= 1'b0;
      food_received_2 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go_signal && food_valid_1) begin
            slot2 <= 1'b0;
            state <= GEN;
          end else if (go_signal && food_valid_2) begin
            slot2 <= 1'b1;
            state <= GEN;
          end
        end
        GEN: begin
          idx   <= 6'd0;
          hit   <= 1'b0;
          state <= CHECK;
        end
        CHECK: begin
          hit <= hit | scan_hit;
          idx <= idx + 6'd1;
          if (idx == 6'd63) begin
            // Outputs land on the edge into DONE so the pulse is visible during DONE itself.
            if ((hit | scan_hit) && (retries < RETRY_LIM)) begin
              retries <= retries + 1'b1;
              state   <= GEN;
            end else begin
              state <= DONE;
              if (slot2) begin
                new_food_x2     <= cand_x;
                new_food_y2     <= cand_y;
                food_received_2 <= 1'b1;
              end else begin
                new_food_x1     <= cand_x;
                new_food_y1     <= cand_y;
                food_received_1 <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          food_received_1 <= 1'b0;
          food_received_2 <= 1'b0;
          retries         <= '0;
          state           <= HOLD;
        end
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
